// File: rtl/bram_l11_ctrl.sv
// ---------------------------------------------------------------------------
// bram_l11_ctrl
//
// Sequencer for the layer-11 feature-map BRAM bank. A job first fills the
// bank with a producer stream (two words per beat), then drains it back to
// the convolution engine (two words per beat) through a 2-entry output FIFO
// so the consumer can stall at any time.
//
// Optional feature: define BRAM_CTRL_REPEAT_EN to replay the drain phase
// rd_passes times (0 treated as 1). Without it exactly one drain pass runs.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, len, rd_passes   job request (sampled in IDLE only)
//   wr_valid/wr_ready       producer handshake, wr_data1/2 = even/odd word
//   rd_valid/rd_ready       consumer handshake, rd_data1/2 = even/odd word
//   busy, done              status; done is a one-cycle end-of-job pulse
//   bram_addr1/2, bram_in1/2, bram_wr, bram_out1/2   bank ports
//   dbg_state_o             current FSM state
//
// Handshake rule (both sides): a transfer happens in a cycle where valid
// and ready are both high at the rising edge; valid never depends on ready.
// ---------------------------------------------------------------------------
module bram_l11_ctrl #(
  parameter int N_BRAM = 8,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W:0]       len,
  input  logic [3:0]            rd_passes,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [N_BRAM*16-1:0]  wr_data1,
  input  logic [N_BRAM*16-1:0]  wr_data2,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [N_BRAM*16-1:0]  rd_data1,
  output logic [N_BRAM*16-1:0]  rd_data2,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     bram_addr1,
  output logic [ADDR_W-1:0]     bram_addr2,
  output logic [N_BRAM*16-1:0]  bram_in1,
  output logic [N_BRAM*16-1:0]  bram_in2,
  output logic                  bram_wr,
  input  logic [N_BRAM*16-1:0]  bram_out1,
  input  logic [N_BRAM*16-1:0]  bram_out2,
  output logic [1:0]            dbg_state_o
);

  localparam int DW = N_BRAM * 16;
  localparam logic [ADDR_W:0] PTR_TWO = (ADDR_W+1)'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  // Pointers are ADDR_W+1 bits so a full-depth job (len = 2**ADDR_W) ends
  // without wrapping.
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] pcnt_q, pcnt_d;     // words popped in the current pass
  logic [3:0]      ipass_q, ipass_d;   // issue passes left after this one
  logic [3:0]      ppass_q, ppass_d;   // pop passes left after this one
  logic            inflight_q;         // read issued last cycle

  logic [2*DW-1:0] fifo_mem_q [2];
  logic            fifo_wp_q, fifo_rp_q;
  logic [1:0]      fifo_cnt_q;

  logic            issue;
  logic            pop;
  logic            room;
  logic [1:0]      occ_after_pop;
  logic [3:0]      passes_m1;

  assign rd_valid = (fifo_cnt_q != 2'd0);
  assign pop      = rd_valid & rd_ready;
  assign rd_data1 = fifo_mem_q[fifo_rp_q][2*DW-1:DW];
  assign rd_data2 = fifo_mem_q[fifo_rp_q][DW-1:0];

  // Occupancy is counted after this cycle's pop so a streaming consumer
  // keeps one read in flight and one pair buffered every cycle.
  assign occ_after_pop = fifo_cnt_q - {1'b0, pop};
  assign room          = (occ_after_pop + {1'b0, inflight_q}) < 2'd2;

  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

`ifdef BRAM_CTRL_REPEAT_EN
  assign passes_m1 = (rd_passes == 4'd0) ? 4'd0 : (rd_passes - 4'd1);
`else
  wire unused_rd_passes = ^rd_passes;
  assign passes_m1 = 4'd0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    pcnt_d     = pcnt_q;
    ipass_d    = ipass_q;
    ppass_d    = ppass_q;
    wr_ready   = 1'b0;
    bram_wr    = 1'b0;
    bram_addr1 = '0;
    bram_addr2 = '0;
    bram_in1   = '0;
    bram_in2   = '0;
    issue      = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = {len[ADDR_W:1], 1'b0};
          ptr_d   = '0;
          pcnt_d  = '0;
          ipass_d = passes_m1;
          ppass_d = passes_m1;
          state_d = (len[ADDR_W:1] == '0) ? S_DONE : S_FILL;
        end
      end

      S_FILL: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          bram_wr    = 1'b1;
          bram_addr1 = ptr_q[ADDR_W-1:0];
          bram_addr2 = {ptr_q[ADDR_W-1:1], 1'b1};  // ptr is always even
          bram_in1   = wr_data1;
          bram_in2   = wr_data2;
          if (ptr_q + PTR_TWO == len_q) begin
            ptr_d   = '0;
            state_d = S_DRAIN;
          end else begin
            ptr_d = ptr_q + PTR_TWO;
          end
        end
      end

      S_DRAIN: begin
        if ((ptr_q < len_q) && room) begin
          issue      = 1'b1;
          bram_addr1 = ptr_q[ADDR_W-1:0];
          bram_addr2 = {ptr_q[ADDR_W-1:1], 1'b1};
          // Rewind at the last issue of a pass so the next pass starts
          // immediately instead of waiting for the pops to catch up.
          if ((ptr_q + PTR_TWO == len_q) && (ipass_q != 4'd0)) begin
            ptr_d   = '0;
            ipass_d = ipass_q - 4'd1;
          end else begin
            ptr_d = ptr_q + PTR_TWO;
          end
        end
        if (pop) begin
          if (pcnt_q + PTR_TWO == len_q) begin
            pcnt_d = '0;
            if (ppass_q == 4'd0) begin
              state_d = S_DONE;
            end else begin
              ppass_d = ppass_q - 4'd1;
            end
          end else begin
            pcnt_d = pcnt_q + PTR_TWO;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      len_q         <= '0;
      pcnt_q        <= '0;
      ipass_q       <= '0;
      ppass_q       <= '0;
      inflight_q    <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wp_q     <= 1'b0;
      fifo_rp_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      pcnt_q     <= pcnt_d;
      ipass_q    <= ipass_d;
      ppass_q    <= ppass_d;
      inflight_q <= issue;
      // Bank data for last cycle's read is valid now; capture it.
      if (inflight_q) begin
        fifo_mem_q[fifo_wp_q] <= {bram_out1, bram_out2};
        fifo_wp_q             <= ~fifo_wp_q;
      end
      if (pop) begin
        fifo_rp_q <= ~fifo_rp_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bram_l11_ctrl.sv
module tb_bram_l11_ctrl;

  localparam int N_BRAM = 8;
  localparam int ADDR_W = 10;
  localparam int DW     = N_BRAM * 16;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef BRAM_CTRL_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic              start = 1'b0;
  logic [ADDR_W:0]   len_s = '0;
  logic [3:0]        rd_passes = 4'd0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DW-1:0]     wr_data1 = '0, wr_data2 = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DW-1:0]     rd_data1, rd_data2;
  logic              busy, done;
  logic [ADDR_W-1:0] bram_addr1, bram_addr2;
  logic [DW-1:0]     bram_in1, bram_in2;
  logic              bram_wr;
  logic [DW-1:0]     bram_out1 = '0, bram_out2 = '0;
  logic [1:0]        dbg_state;

  bram_l11_ctrl #(.N_BRAM(N_BRAM), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len_s), .rd_passes(rd_passes),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data1(wr_data1), .wr_data2(wr_data2),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .busy(busy), .done(done), .bram_addr1(bram_addr1), .bram_addr2(bram_addr2),
    .bram_in1(bram_in1), .bram_in2(bram_in2), .bram_wr(bram_wr),
    .bram_out1(bram_out1), .bram_out2(bram_out2), .dbg_state_o(dbg_state)
  );

  // Bank model: one-cycle read latency, shared write enable.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bram_wr) begin
      mem[bram_addr1] <= bram_in1;
      mem[bram_addr2] <= bram_in2;
    end
    bram_out1 <= mem[bram_addr1];
    bram_out2 <= mem[bram_addr2];
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   d1_a [0:DEPTH/2-1];
  logic [DW-1:0]   d2_a [0:DEPTH/2-1];

  task automatic check(input string name, input logic [2*DW-1:0] act,
                       input logic [2*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int got, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Monitor state, reset per job.
  int wr_cnt, pop_cnt, done_cnt;
  int first_wr_cyc, last_wr_cyc, first_rv_cyc, last_pop_cyc, done_cyc;
  logic [ADDR_W-1:0] exp_waddr, last_a1, last_a2;
  bit prev_stall = 1'b0;
  logic [2*DW-1:0] prev_data;

  task automatic clear_mon();
    wr_cnt = 0; pop_cnt = 0; done_cnt = 0;
    first_wr_cyc = -1; last_wr_cyc = -1; first_rv_cyc = -1;
    last_pop_cyc = -1; done_cyc = -1;
    exp_waddr = '0; last_a1 = '0; last_a2 = '0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    logic [ADDR_W-1:0] a2_exp;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bram_wr) begin
        a2_exp = exp_waddr + 1'b1;
        check("wr_addr1", bram_addr1, exp_waddr);
        check("wr_addr2", bram_addr2, a2_exp);
        check("wr_data", {bram_in1, bram_in2}, {wr_data1, wr_data2});
        if (wr_cnt == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        last_a1 = bram_addr1;
        last_a2 = bram_addr2;
        wr_cnt++;
        exp_waddr = exp_waddr + 2'd2;
      end
      if (prev_stall) begin
        check("stall_valid", rd_valid, 1);
        check("stall_data", {rd_data1, rd_data2}, prev_data);
      end
      if (rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) fail_now("pop_unexpected", pop_cnt + 1, pop_cnt);
        else check("pop_data", {rd_data1, rd_data2}, exp_q.pop_front());
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = {rd_data1, rd_data2};
    end
  end

  // Consumer ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random.
  int rmode_g = 0;
  int tog = 0;
  always @(posedge clk) begin
    #1;
    case (rmode_g)
      0: rd_ready = 1'b1;
      1: rd_ready = (tog % 3 == 0);
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
    tog++;
  end

  // ---------------- driver tasks ----------------
  task automatic gen_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      d1_a[i] = {$urandom, $urandom, $urandom, $urandom};
      d2_a[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic fill(input int n, input int vmode);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 8 * n + 20) begin
      wr_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      wr_data1 = d1_a[i];
      wr_data2 = d2_a[i];
      @(negedge clk);
      acc = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    wr_valid = 1'b0;
    if (i < n) fail_now("fill_timeout", i, n);
  endtask

  task automatic pulse_start(input int len, input int passes, output int s_cyc);
    start = 1'b1;
    len_s = len[ADDR_W:0];
    rd_passes = passes[3:0];
    @(negedge clk);
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int len, input int passes, input int rmode,
                         input int vmode, input int exp_wr, input int exp_pop,
                         input bit directed);
    int n, peff, s_cyc, guard;
    n = len >> 1;
    peff = REP ? ((passes == 0) ? 1 : passes) : 1;
    clear_mon();
    gen_pairs(n);
    for (int p = 0; p < peff; p++)
      for (int i = 0; i < n; i++) exp_q.push_back({d1_a[i], d2_a[i]});
    rmode_g = rmode;
    pulse_start(len, passes, s_cyc);
    fill(n, vmode);
    guard = 0;
    while (done_cnt == 0 && guard < 40 * n * peff + 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (done_cnt == 0) fail_now("done_timeout", guard, 0);
    repeat (4) @(posedge clk);
    #1;
    check("wr_count", wr_cnt, exp_wr);
    check("pop_count", pop_cnt, exp_pop);
    check("exp_left", exp_q.size(), 0);
    check("done_count", done_cnt, 1);
    check("busy_end", busy, 0);
    if (n > 0) check("done_after_pop", done_cyc - last_pop_cyc, 1);
    else check("len0_done_delay", (done_cyc - s_cyc >= 1) && (done_cyc - s_cyc <= 2), 1);
    if (directed) begin
      check("first_wr_lat", first_wr_cyc - s_cyc, 1);
      check("fill_rate", last_wr_cyc - first_wr_cyc, n - 1);
      check("drain_lat", first_rv_cyc - last_wr_cyc, 3);
    end
    if (len == DEPTH) begin
      check("last_addr1", last_a1, DEPTH - 2);
      check("last_addr2", last_a2, DEPTH - 1);
    end
  endtask

  // ---------------- test ----------------
  typedef struct {
    int len;
    int passes;
    int rmode;
    int vmode;
    int exp_wr;
    int exp_pop;
    bit directed;
  } job_t;

  job_t jobs[8];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_cyc;
    jobs[0] = '{8,    1, 0, 0, 4,   4,                1'b1};
    jobs[1] = '{8,    1, 1, 0, 4,   4,                1'b0};
    jobs[2] = '{0,    1, 0, 0, 0,   0,                1'b0};
    jobs[3] = '{1024, 1, 0, 0, 512, 512,              1'b0};
    jobs[4] = '{7,    1, 2, 1, 3,   3,                1'b0};
    jobs[5] = '{4,    3, 0, 0, 2,   (REP ? 6 : 2),    1'b0};
    jobs[6] = '{4,    0, 1, 0, 2,   2,                1'b0};
    jobs[7] = '{2,    2, 2, 1, 1,   (REP ? 2 : 1),    1'b0};

    clear_mon();
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bram_wr", bram_wr, 0);
    check("rst_addr", {bram_addr1, bram_addr2}, 0);
    check("rst_in", {bram_in1, bram_in2}, 0);
    check("rst_rd_data", {rd_data1, rd_data2}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset in the middle of a fill after three beats
    clear_mon();
    gen_pairs(4);
    pulse_start(8, 1, s_cyc);
    fill(3, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_bram_wr", bram_wr, 0);
    check("midrst_wr_ready", wr_ready, 0);
    check("midrst_writes", wr_cnt, 3);
    @(posedge clk); #1;

    // Table-driven jobs
    for (int j = 0; j < 8; j++)
      run_job(jobs[j].len, jobs[j].passes, jobs[j].rmode, jobs[j].vmode,
              jobs[j].exp_wr, jobs[j].exp_pop, jobs[j].directed);

    // Randomized jobs against the reference model
    for (int k = 0; k < 12; k++) begin
      int l, ps, peff;
      l  = $urandom_range(0, 40);
      ps = $urandom_range(0, 4);
      peff = REP ? ((ps == 0) ? 1 : ps) : 1;
      run_job(l, ps, $urandom_range(0, 2), $urandom_range(0, 1),
              l >> 1, (l >> 1) * peff, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
